cla_serial_addsub: RTL and testbench



---
 rtl/cla_serial_addsub.sv | 123 ++++++++++++
 tb/tb_cla_serial_addsub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_addsub.sv
// cla_serial_addsub: digit-serial WIDTH-bit adder/subtractor.
// One 4-bit nibble is resolved per cycle with carry-lookahead logic. The
// nibble's group carry is registered and becomes the next nibble's carry-in.
// WIDTH must be a multiple of 4 and at least 4.
module cla_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [IDXW+1:0]  bit_base;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       grp_g;
  logic       grp_p;
  logic       grp_c;
  logic [3:0] sum_nib;
  logic       accept;
  logic       last_nib;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign last_nib  = (idx == IDXW'(NIBBLES - 1));
  assign bit_base  = {idx, 2'b00};

  // Lookahead evaluation of the nibble currently selected by idx.
  always_comb begin
    a_nib   = op_a[bit_base +: 4];
    b_nib   = op_b[bit_base +: 4];
    p       = a_nib ^ b_nib;
    g       = a_nib & b_nib;
    c1      = g[0] | (p[0] & carry);
    c2      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry);
    grp_g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
    grp_p   = &p;
    grp_c   = grp_g | (grp_p & carry);
    sum_nib = p ^ {c3, c2, c1, carry};
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, walk the nibbles, wait for retire.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)  state_next = RUN;
      RUN:  if (last_nib)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Operand capture, per-nibble result write-back and carry feedback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        idx   <= '0;
      end else if (state == RUN) begin
        sum[bit_base +: 4] <= sum_nib;
        carry              <= grp_c;
        idx                <= idx + 1'b1;
        if (last_nib) begin
          cout <= grp_c;
          ovf  <= c3 ^ grp_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed self-checking bench for cla_serial_addsub (WIDTH = 16).
module tb_cla_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  cla_serial_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // One comparison point: counts the test and reports any mismatch.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation and hold in_valid until the accept edge.
  task automatic apply_stimulus(input logic [15:0] va, input logic [15:0] vb,
                                input logic vsub, input logic vcin);
    @(negedge clk);
    a        = va;
    b        = vb;
    sub      = vsub;
    cin      = vcin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    sub      = ~vsub;
    cin      = ~vcin;
  endtask

  // Count edges after acceptance until out_valid, bounded, then check result.
  task automatic run_op(input string tag, input logic [15:0] va,
                        input logic [15:0] vb, input logic vsub,
                        input logic vcin, input logic [15:0] esum,
                        input logic ecout, input logic eovf);
    int cyc;
    check_output({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    apply_stimulus(va, vb, vsub, vcin);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    check_output({tag, "_latency"}, cyc, 32'd4);
    check_output({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    check_output({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    check_output({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
  endtask

  // Retire the result with a single out_ready edge.
  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output({tag, "_ret_ready"}, {31'd0, in_ready}, 32'd1);
    check_output({tag, "_ret_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b0;
    #12;
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_sum", {16'd0, sum}, 32'd0);
    check_output("rst_cout", {31'd0, cout}, 32'd0);
    check_output("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    retire("add_basic");
    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    retire("ripple1");
    run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    retire("ripple_cin");
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    retire("add_ovf");
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    retire("sub_ovf");
    run_op("sub_borrow", 16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    retire("sub_borrow");
    run_op("sub_equal", 16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    retire("sub_equal");

    // Backpressure: hold DONE with new operands offered; nothing may move.
    run_op("hold", 16'h00A5, 16'h0100, 1'b0, 1'b0, 16'h01A5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a        = 16'h1111;
      b        = 16'h2222;
      sub      = 1'b0;
      cin      = 1'b0;
      in_valid = (i % 2) == 0;
      @(posedge clk);
      #1;
      check_output("hold_sum", {16'd0, sum}, 32'h01A5);
      check_output("hold_cout", {31'd0, cout}, 32'd0);
      check_output("hold_ovf", {31'd0, ovf}, 32'd0);
      check_output("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    retire("hold");
    run_op("after_hold", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    retire("after_hold");

    // Reset during the second RUN cycle of a full-ripple add.
    @(negedge clk);
    a        = 16'hFFFF;
    b        = 16'h0001;
    sub      = 1'b0;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("arst_sum", {16'd0, sum}, 32'd0);
    check_output("arst_cout", {31'd0, cout}, 32'd0);
    check_output("arst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_output("arst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    retire("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
